// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// requester (i_*) and a data requester (d_*).
//
// Build option: define MEM_ARB_RR_EN to replace fixed d-over-i priority and
// its fetch starvation counter with round-robin arbitration.
//
// Handshake: a requester raises *_req with its fields stable. *_ack is
// combinational and marks the cycle in which the access is presented to
// memory. *_rsp_valid pulses high for exactly one cycle on the following
// cycle, carrying that access's load data and alignment error. If *_req is
// dropped before the ack, the request is cancelled and no response is
// produced.

package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_width_t;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AddrWidth = 8,
  parameter int MaxWait   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,

  // instruction-fetch requester
  input  logic                 i_req,
  input  logic                 i_write_enable,
  input  mem_width_t           i_width,
  input  logic                 i_sign_extend,
  input  logic [AddrWidth-1:0] i_address,
  input  logic [31:0]          i_data_in,
  output logic                 i_ack,
  output logic                 i_rsp_valid,
  output logic [31:0]          i_rsp_data,
  output logic                 i_rsp_error,

  // data requester
  input  logic                 d_req,
  input  logic                 d_write_enable,
  input  mem_width_t           d_width,
  input  logic                 d_sign_extend,
  input  logic [AddrWidth-1:0] d_address,
  input  logic [31:0]          d_data_in,
  input  logic                 d_lock,
  output logic                 d_ack,
  output logic                 d_rsp_valid,
  output logic [31:0]          d_rsp_data,
  output logic                 d_rsp_error,

  // shared memory port
  output logic                 mem_write_enable,
  output mem_width_t           mem_width,
  output logic                 mem_sign_extend,
  output logic [AddrWidth-1:0] mem_address,
  output logic [31:0]          mem_data_in,
  input  logic [31:0]          mem_data_out,
  input  logic                 mem_alignment_error,

  // observation of internal state
  output logic [0:0]           dbg_state,
  output logic [3:0]           dbg_wait_cnt,
  output logic                 dbg_last_grant
);

  // Arbiter states: normal arbitration, or data port holding the memory.
  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCK_D = 1'b1;

  // Encoding of the most recently granted requester.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [0:0] state;
  logic [0:0] state_next;
  logic       last_grant;
  logic       granted_we;

`ifndef MEM_ARB_RR_EN
  // Saturation point of the fetch starvation counter.
  localparam logic [3:0] WAIT_MAX = 4'(MaxWait);

  logic [3:0] wait_cnt;
`endif

  // Per-cycle grant decision. A locked data port excludes fetch entirely.
  // When both ports request, the default build prefers data unless fetch
  // has waited the maximum; the round-robin build alternates.
  always_comb begin
    i_ack = 1'b0;
    d_ack = 1'b0;
    if (state == ST_LOCK_D) begin
      d_ack = d_req;
    end else if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      if (last_grant == GRANT_D) begin
        i_ack = 1'b1;
      end else begin
        d_ack = 1'b1;
      end
`else
      if (wait_cnt == WAIT_MAX) begin
        i_ack = 1'b1;
      end else begin
        d_ack = 1'b1;
      end
`endif
    end else begin
      i_ack = i_req;
      d_ack = d_req;
    end
  end

  // Memory port mux: granted requester's fields, all zero when idle.
  always_comb begin
    granted_we      = 1'b0;
    mem_width       = BYTE;
    mem_sign_extend = 1'b0;
    mem_address     = '0;
    mem_data_in     = 32'd0;
    if (d_ack) begin
      granted_we      = d_write_enable;
      mem_width       = d_width;
      mem_sign_extend = d_sign_extend;
      mem_address     = d_address;
      mem_data_in     = d_data_in;
    end else if (i_ack) begin
      granted_we      = i_write_enable;
      mem_width       = i_width;
      mem_sign_extend = i_sign_extend;
      mem_address     = i_address;
      mem_data_in     = i_data_in;
    end
  end

  // Misaligned stores never reach the array. Kept apart from the mux so the
  // alignment result from memory does not feed back into the address path.
  assign mem_write_enable = granted_we & ~mem_alignment_error;

  // Lock entry happens on a locked data grant; lock exit happens as soon as
  // d_lock is released, with or without a request in that cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_ARB: begin
        if (d_ack && d_lock) begin
          state_next = ST_LOCK_D;
        end
      end
      ST_LOCK_D: begin
        if (!d_lock) begin
          state_next = ST_ARB;
        end
      end
      default: state_next = ST_ARB;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_ARB;
    end else begin
      state <= state_next;
    end
  end

  // Remember the last granted port; the round-robin build uses it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= GRANT_I;
    end else if (d_ack) begin
      last_grant <= GRANT_D;
    end else if (i_ack) begin
      last_grant <= GRANT_I;
    end
  end

`ifndef MEM_ARB_RR_EN
  // Count consecutive stalled fetch cycles; frozen while data is locked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 4'd0;
    end else if (state == ST_ARB) begin
      if (i_req && !i_ack) begin
        if (wait_cnt != WAIT_MAX) begin
          wait_cnt <= wait_cnt + 4'd1;
        end
      end else begin
        wait_cnt <= 4'd0;
      end
    end
  end

  assign dbg_wait_cnt = wait_cnt;
`else
  assign dbg_wait_cnt = 4'd0;
`endif

  // Fetch response: capture load data and alignment status at the ack edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_rsp_valid <= 1'b0;
      i_rsp_data  <= 32'd0;
      i_rsp_error <= 1'b0;
    end else begin
      i_rsp_valid <= i_ack;
      if (i_ack) begin
        i_rsp_data  <= i_write_enable ? 32'd0 : mem_data_out;
        i_rsp_error <= mem_alignment_error;
      end
    end
  end

  // Data response: same capture rule as fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_rsp_valid <= 1'b0;
      d_rsp_data  <= 32'd0;
      d_rsp_error <= 1'b0;
    end else begin
      d_rsp_valid <= d_ack;
      if (d_ack) begin
        d_rsp_data  <= d_write_enable ? 32'd0 : mem_data_out;
        d_rsp_error <= mem_alignment_error;
      end
    end
  end

  assign dbg_state      = state;
  assign dbg_last_grant = last_grant;

endmodule
